// File: rtl/alu1_divider_if.sv
// Request/result handshake and Alu1 bus of the restoring divider.
// slave = divider side, master = requester plus external Alu1.
interface alu1_divider_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;

  logic [2:0]       alu_cmd;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic             alu_co;
  logic [WIDTH-1:0] alu_out;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport slave (
    input  start_valid,
    input  dividend,
    input  divisor,
    output start_ready,
    output alu_cmd,
    output alu_in1,
    output alu_in2,
    input  alu_co,
    input  alu_out,
    output res_valid,
    input  res_ready,
    output quotient,
    output remainder,
    output div_by_zero
  );

  modport master (
    output start_valid,
    output dividend,
    output divisor,
    input  start_ready,
    input  alu_cmd,
    input  alu_in1,
    input  alu_in2,
    output alu_co,
    output alu_out,
    input  res_valid,
    output res_ready,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );
endinterface

// File: rtl/alu1_divider.sv
// Multi-cycle unsigned restoring divider.
// One Alu1 SUB per iteration; quotient bit from the carry.
module alu1_divider #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  alu1_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] CMD_TRANSFER = 3'd0;
  localparam logic [2:0] CMD_SUB      = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dq_q;
  logic [WIDTH-1:0] dq_d;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] dsr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             dbz_q;
  logic             dbz_d;

  logic [WIDTH-1:0] partial;
  logic             qbit;
  logic             accept;
  logic             last_iter;

  // Shift the next dividend bit into the running remainder.
  assign partial = {rem_q[WIDTH-2:0], dq_q[WIDTH-1]};

  // A bit shifted out of rem means partial exceeds any divisor.
  assign qbit = rem_q[WIDTH-1] | bus.alu_co;

  assign accept    = (state_q == IDLE) & bus.start_valid;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dq_q    <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state, datapath update and Alu1 drive.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    dq_d        = dq_q;
    dsr_d       = dsr_q;
    cnt_d       = cnt_q;
    dbz_d       = dbz_q;
    bus.alu_cmd = CMD_TRANSFER;
    bus.alu_in1 = '0;
    bus.alu_in2 = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dsr_d = bus.divisor;
          dq_d  = bus.dividend;
          rem_d = '0;
          cnt_d = '0;
          if (bus.divisor != '0) begin
            state_d = CALC;
            dbz_d   = 1'b0;
          end else begin
            state_d = DONE;
            dq_d    = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end
        end
      end

      CALC: begin
        bus.alu_cmd = CMD_SUB;
        bus.alu_in1 = partial;
        bus.alu_in2 = dsr_q;
        rem_d       = qbit ? bus.alu_out : partial;
        dq_d        = {dq_q[WIDTH-2:0], qbit};
        cnt_d       = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.res_valid   = (state_q == DONE);
  assign bus.quotient    = dq_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu1_divider.sv
// Bench for alu1_divider at WIDTH=8 and WIDTH=16.
// Alu1 modelled behaviourally; results checked against / and %.
module tb_alu1_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel16;
  logic        sv;
  logic        rr;
  logic [15:0] opa;
  logic [15:0] opb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu1_divider_if #(.WIDTH(8))  b8 ();
  alu1_divider_if #(.WIDTH(16)) b16 ();

  alu1_divider #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b8)
  );

  alu1_divider #(.WIDTH(16)) dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b16)
  );

  assign b8.start_valid  = sv & ~sel16;
  assign b8.dividend     = opa[7:0];
  assign b8.divisor      = opb[7:0];
  assign b8.res_ready    = rr;
  assign b16.start_valid = sv & sel16;
  assign b16.dividend    = opa;
  assign b16.divisor     = opb;
  assign b16.res_ready   = rr;

  // Alu1 model: SUB gives difference and no-borrow carry, else transfer.
  assign b8.alu_out  = (b8.alu_cmd == 3'd5) ? b8.alu_in1 - b8.alu_in2
                                            : b8.alu_in1;
  assign b8.alu_co   = (b8.alu_cmd == 3'd5) && (b8.alu_in1 >= b8.alu_in2);
  assign b16.alu_out = (b16.alu_cmd == 3'd5) ? b16.alu_in1 - b16.alu_in2
                                             : b16.alu_in1;
  assign b16.alu_co  = (b16.alu_cmd == 3'd5) && (b16.alu_in1 >= b16.alu_in2);

  logic [15:0] q_o;
  logic [15:0] r_o;
  logic [15:0] in1_o;
  logic        rv;
  logic        sr;
  logic        dz;
  logic [2:0]  cmd;

  always_comb begin
    if (sel16) begin
      q_o   = b16.quotient;
      r_o   = b16.remainder;
      in1_o = b16.alu_in1;
      rv    = b16.res_valid;
      sr    = b16.start_ready;
      dz    = b16.div_by_zero;
      cmd   = b16.alu_cmd;
    end else begin
      q_o   = {8'h00, b8.quotient};
      r_o   = {8'h00, b8.remainder};
      in1_o = {8'h00, b8.alu_in1};
      rv    = b8.res_valid;
      sr    = b8.start_ready;
      dz    = b8.div_by_zero;
      cmd   = b8.alu_cmd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rv"}, 32'(rv), 32'd0);
    chk({tag, "_sr"}, 32'(sr), 32'd1);
    chk({tag, "_q"}, 32'(q_o), 32'd0);
    chk({tag, "_r"}, 32'(r_o), 32'd0);
    chk({tag, "_dbz"}, 32'(dz), 32'd0);
    chk({tag, "_cmd"}, 32'(cmd), 32'd0);
    chk({tag, "_in1"}, 32'(in1_o), 32'd0);
  endtask

  // One division: accept, wait for result, optional stall, handshake.
  task automatic go(input bit w, input logic [15:0] a_in,
                    input logic [15:0] b_in, input int stall);
    logic [15:0] m;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eq;
    logic [15:0] er;
    int          lat;
    int          n5;
    m  = w ? 16'hFFFF : 16'h00FF;
    a  = a_in & m;
    b  = b_in & m;
    eq = (b == 0) ? m : a / b;
    er = (b == 0) ? a : a % b;
    sel16 = w;
    opa   = a;
    opb   = b;
    sv    = 1'b1;
    rr    = (stall == 0);
    chk("accept_sr", 32'(sr), 32'd1);
    step();
    sv  = 1'b0;
    lat = 1;
    n5  = 0;
    while (!rv && lat < 60) begin
      if (cmd == 3'd5) n5++;
      step();
      lat++;
    end
    chk("latency", 32'(lat), (b == 0) ? 32'd1 : (w ? 32'd17 : 32'd9));
    chk("n_sub", 32'(n5), (b == 0) ? 32'd0 : (w ? 32'd16 : 32'd8));
    chk("quot", 32'(q_o), 32'(eq));
    chk("rem", 32'(r_o), 32'(er));
    chk("dbz", 32'(dz), 32'(b == 0));
    chk("done_sr", 32'(sr), 32'd0);
    for (int i = 0; i < stall; i++) begin
      if (i == 1) begin
        opa = ~a;
        opb = 16'd3;
        sv  = 1'b1;
      end
      step();
      sv = 1'b0;
      chk("hold_q", 32'(q_o), 32'(eq));
      chk("hold_r", 32'(r_o), 32'(er));
      chk("hold_dbz", 32'(dz), 32'(b == 0));
      chk("hold_rv", 32'(rv), 32'd1);
      chk("hold_sr", 32'(sr), 32'd0);
    end
    rr = 1'b1;
    step();
    chk("turn_sr", 32'(sr), 32'd1);
    chk("turn_rv", 32'(rv), 32'd0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int          ms;
    rst_n = 1'b0;
    sel16 = 1'b0;
    sv    = 1'b0;
    rr    = 1'b1;
    opa   = '0;
    opb   = '0;
    step();
    step();
    chk_idle("rst8");
    sel16 = 1'b1;
    #1;
    chk_idle("rst16");
    sel16 = 1'b0;
    rst_n = 1'b1;
    step();

    go(1'b0, 16'd100, 16'd7, 0);
    go(1'b0, 16'd255, 16'd129, 0);
    go(1'b0, 16'd5, 16'd10, 0);
    go(1'b0, 16'd255, 16'd255, 0);
    go(1'b0, 16'd255, 16'd1, 0);
    go(1'b0, 16'd200, 16'd0, 0);
    go(1'b0, 16'd100, 16'd7, 5);
    go(1'b1, 16'd50000, 16'd7, 2);
    go(1'b1, 16'd65535, 16'd32769, 0);
    go(1'b1, 16'd1234, 16'd0, 3);

    // Reset during the 4th CALC cycle aborts the division.
    sel16 = 1'b0;
    opa   = 16'd100;
    opb   = 16'd7;
    sv    = 1'b1;
    step();
    sv = 1'b0;
    step();
    step();
    step();
    chk("mid_calc_cmd", 32'(cmd), 32'd5);
    rst_n = 1'b0;
    step();
    chk_idle("abort");
    rst_n = 1'b1;
    go(1'b0, 16'd9, 16'd3, 0);

    for (int k = 0; k < 1500; k++) begin
      ra = 16'($urandom);
      ms = $urandom_range(0, 8);
      rb = 16'($urandom) & 16'((1 << ms) - 1);
      if ($urandom_range(0, 7) == 0) rb = '0;
      go(1'b0, ra, rb, $urandom_range(0, 3));
    end
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom);
      ms = $urandom_range(0, 16);
      rb = 16'($urandom) & 16'((32'd1 << ms) - 1);
      if ($urandom_range(0, 7) == 0) rb = '0;
      go(1'b1, ra, rb, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
